// File: rtl/itlb_miss_ctrl_pkg.sv
// Shared types and sizing for the ITLB miss controller.
package itlb_miss_ctrl_pkg;

  localparam int unsigned ITLB_L2_TLB_REQ_TAG_COUNT = 4;
  localparam int unsigned ITLB_L2_TLB_REQ_TAG_WIDTH = 2;
  localparam int unsigned VPN_WIDTH                 = 20;
  localparam int unsigned ASID_WIDTH                = 9;
  localparam int unsigned ITLB_4KBPAGE_SETS         = 4;
  localparam int unsigned ITLB_4KBPAGE_WAYS         = 4;
  localparam int unsigned ITLB_4MBPAGE_SETS         = 2;
  localparam int unsigned ITLB_4MBPAGE_WAYS         = 2;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    PEND  = 2'd1,
    WAIT  = 2'd2,
    STALE = 2'd3
  } itlb_miss_tag_state_t;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

endpackage

// File: rtl/itlb_miss_ctrl_plru_tree4.sv
// 3-bit tree PLRU for one 4-way set; the hit touch is applied before the fill touch.
module plru_tree4 (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       hit_valid,
  input  logic [1:0] hit_way,
  input  logic       fill_valid,
  input  logic [1:0] fill_way,
  output logic [1:0] victim_way_c
);

  // tree[0] = root (1: victim on right half), tree[1] = ways 0/1, tree[2] = ways 2/3
  logic [2:0] tree_q, tree_d;

  function automatic logic [2:0] touch(input logic [2:0] t, input logic [1:0] way);
    logic [2:0] r;
    r    = t;
    r[0] = ~way[1];
    if (way[1]) r[2] = ~way[0];
    else        r[1] = ~way[0];
    return r;
  endfunction

  always_comb begin
    tree_d = tree_q;
    if (hit_valid)  tree_d = touch(tree_d, hit_way);
    if (fill_valid) tree_d = touch(tree_d, fill_way);
    victim_way_c = tree_q[0] ? {1'b1, tree_q[2]} : {1'b0, tree_q[1]};
  end

  always_ff @(posedge CLK) begin
    if (!nRST) tree_q <= 3'b000;
    else       tree_q <= tree_d;
  end

endmodule

// File: rtl/itlb_miss_ctrl.sv
// ITLB refill sequencer: tag allocation/merge, L2 TLB request issue, fill/fault routing, PLRU.
module itlb_miss_ctrl
  import itlb_miss_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        miss_valid,
  input  logic [19:0] miss_VPN,
  input  logic [8:0]  miss_ASID,
  output logic        miss_ready,
  input  logic        hit_valid,
  input  logic        hit_is_4MB,
  input  logic [1:0]  hit_index,
  input  logic [1:0]  hit_way,
  output logic        l2_req_valid,
  input  logic        l2_req_ready,
  output logic [1:0]  l2_req_tag,
  output logic [19:0] l2_req_VPN,
  output logic [8:0]  l2_req_ASID,
  input  logic        l2_resp_valid,
  input  logic [1:0]  l2_resp_tag,
  input  pte_t        l2_resp_pte,
  input  logic        l2_resp_is_4MB,
  input  logic        l2_resp_fault,
  input  logic        flush_valid,
  output logic        fill_valid,
  output logic        fill_is_4MB,
  output logic [1:0]  fill_index,
  output logic [1:0]  fill_way,
  output logic [19:0] fill_VPN,
  output logic [8:0]  fill_ASID,
  output pte_t        fill_pte,
  output logic        fault_valid,
  output logic [19:0] fault_VPN
);

  localparam int unsigned TC = ITLB_L2_TLB_REQ_TAG_COUNT;
  localparam int unsigned TW = ITLB_L2_TLB_REQ_TAG_WIDTH;

  itlb_miss_tag_state_t  state_q [TC];
  itlb_miss_tag_state_t  state_d [TC];
  logic [VPN_WIDTH-1:0]  vpn_q   [TC];
  logic [VPN_WIDTH-1:0]  vpn_d   [TC];
  logic [ASID_WIDTH-1:0] asid_q  [TC];
  logic [ASID_WIDTH-1:0] asid_d  [TC];

  logic          req_lock_q, req_lock_d;
  logic [TW-1:0] req_sel_q, req_sel_d;

  logic          fill_valid_q, fill_valid_d;
  logic          fill_is_4MB_q, fill_is_4MB_d;
  logic [1:0]    fill_index_q, fill_index_d;
  logic [1:0]    fill_way_q, fill_way_d;
  logic [19:0]   fill_VPN_q, fill_VPN_d;
  logic [8:0]    fill_ASID_q, fill_ASID_d;
  pte_t          fill_pte_q, fill_pte_d;
  logic          fault_valid_q, fault_valid_d;
  logic [19:0]   fault_VPN_q, fault_VPN_d;
  logic [ITLB_4MBPAGE_SETS-1:0] plru4m_q, plru4m_d;

  logic          merge_hit, free_any, pend_any, alloc, accept, resp_live;
  logic [TW-1:0] alloc_idx, pend_idx, req_idx;
  logic [19:0]   resp_vpn;
  logic [1:0]    set4k, victim4k;
  logic          set4m, victim4m;
  logic [1:0]    victim_c   [ITLB_4KBPAGE_SETS];
  logic [ITLB_4KBPAGE_SETS-1:0] hit_touch, fill_touch;

  // Tag lookup: merge match, lowest FREE and lowest PEND entries
  always_comb begin
    merge_hit = 1'b0;
    free_any  = 1'b0;
    pend_any  = 1'b0;
    alloc_idx = '0;
    pend_idx  = '0;
    for (int i = TC - 1; i >= 0; i--) begin
      if (state_q[i] == FREE) begin
        free_any  = 1'b1;
        alloc_idx = TW'(i);
      end
      if (state_q[i] == PEND) begin
        pend_any = 1'b1;
        pend_idx = TW'(i);
      end
      if ((state_q[i] == PEND || state_q[i] == WAIT) &&
          vpn_q[i] == miss_VPN && asid_q[i] == miss_ASID)
        merge_hit = 1'b1;
    end
  end

  // A presented-but-unaccepted request stays locked so a lower new allocation cannot displace it
  assign req_idx      = req_lock_q ? req_sel_q : pend_idx;
  assign l2_req_valid = pend_any;
  assign l2_req_tag   = pend_any ? req_idx : '0;
  assign l2_req_VPN   = pend_any ? vpn_q[req_idx] : '0;
  assign l2_req_ASID  = pend_any ? asid_q[req_idx] : '0;

  assign miss_ready = !flush_valid && (merge_hit || free_any);
  assign alloc      = miss_valid && miss_ready && !merge_hit;
  assign accept     = l2_req_valid && l2_req_ready;
  assign resp_live  = l2_resp_valid && (state_q[l2_resp_tag] == WAIT) && !flush_valid;
  assign resp_vpn   = vpn_q[l2_resp_tag];
  assign set4k      = resp_vpn[1:0];
  assign set4m      = resp_vpn[10];
  assign victim4k   = victim_c[set4k];
  assign victim4m   = plru4m_q[set4m];

  // Per-tag state transitions
  always_comb begin
    state_d    = state_q;
    vpn_d      = vpn_q;
    asid_d     = asid_q;
    req_lock_d = req_lock_q;
    req_sel_d  = req_sel_q;
    for (int i = 0; i < TC; i++) begin
      unique case (state_q[i])
        FREE: if (alloc && alloc_idx == TW'(i)) begin
          state_d[i] = PEND;
          vpn_d[i]   = miss_VPN;
          asid_d[i]  = miss_ASID;
        end
        PEND: begin
          if (accept && req_idx == TW'(i)) state_d[i] = flush_valid ? STALE : WAIT;
          else if (flush_valid)            state_d[i] = FREE;
        end
        WAIT: begin
          if (l2_resp_valid && l2_resp_tag == TW'(i)) state_d[i] = FREE;
          else if (flush_valid)                       state_d[i] = STALE;
        end
        STALE: if (l2_resp_valid && l2_resp_tag == TW'(i)) state_d[i] = FREE;
        default: state_d[i] = FREE;
      endcase
    end
    if (flush_valid || accept) begin
      req_lock_d = 1'b0;
    end else if (l2_req_valid) begin
      req_lock_d = 1'b1;
      req_sel_d  = req_idx;
    end
  end

  // Fill / fault outputs and PLRU touches; victim reads pre-update PLRU state
  always_comb begin
    fill_valid_d  = resp_live && !l2_resp_fault;
    fill_is_4MB_d = 1'b0;
    fill_index_d  = '0;
    fill_way_d    = '0;
    fill_VPN_d    = '0;
    fill_ASID_d   = '0;
    fill_pte_d    = '0;
    fault_valid_d = resp_live && l2_resp_fault;
    fault_VPN_d   = '0;
    if (fill_valid_d) begin
      fill_is_4MB_d = l2_resp_is_4MB;
      fill_index_d  = l2_resp_is_4MB ? {1'b0, set4m} : set4k;
      fill_way_d    = l2_resp_is_4MB ? {1'b0, victim4m} : victim4k;
      fill_VPN_d    = resp_vpn;
      fill_ASID_d   = asid_q[l2_resp_tag];
      fill_pte_d    = l2_resp_pte;
    end
    if (fault_valid_d) fault_VPN_d = resp_vpn;

    plru4m_d = plru4m_q;
    for (int s = 0; s < ITLB_4KBPAGE_SETS; s++) begin
      hit_touch[s]  = hit_valid && !hit_is_4MB && hit_index == 2'(s);
      fill_touch[s] = fill_valid_d && !l2_resp_is_4MB && set4k == 2'(s);
    end
    for (int s = 0; s < ITLB_4MBPAGE_SETS; s++) begin
      if (hit_valid && hit_is_4MB && hit_index[0] == 1'(s))
        plru4m_d[s] = ~hit_way[0];
      if (fill_valid_d && l2_resp_is_4MB && set4m == 1'(s))
        plru4m_d[s] = ~victim4m;
    end
  end

  for (genvar g = 0; g < ITLB_4KBPAGE_SETS; g++) begin : g_plru4k
    plru_tree4 u_plru (
      .CLK          (CLK),
      .nRST         (nRST),
      .hit_valid    (hit_touch[g]),
      .hit_way      (hit_way),
      .fill_valid   (fill_touch[g]),
      .fill_way     (victim4k),
      .victim_way_c (victim_c[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < TC; i++) begin
        state_q[i] <= FREE;
        vpn_q[i]   <= '0;
        asid_q[i]  <= '0;
      end
      req_lock_q    <= 1'b0;
      req_sel_q     <= '0;
      fill_valid_q  <= 1'b0;
      fill_is_4MB_q <= 1'b0;
      fill_index_q  <= '0;
      fill_way_q    <= '0;
      fill_VPN_q    <= '0;
      fill_ASID_q   <= '0;
      fill_pte_q    <= '0;
      fault_valid_q <= 1'b0;
      fault_VPN_q   <= '0;
      plru4m_q      <= '0;
    end else begin
      state_q       <= state_d;
      vpn_q         <= vpn_d;
      asid_q        <= asid_d;
      req_lock_q    <= req_lock_d;
      req_sel_q     <= req_sel_d;
      fill_valid_q  <= fill_valid_d;
      fill_is_4MB_q <= fill_is_4MB_d;
      fill_index_q  <= fill_index_d;
      fill_way_q    <= fill_way_d;
      fill_VPN_q    <= fill_VPN_d;
      fill_ASID_q   <= fill_ASID_d;
      fill_pte_q    <= fill_pte_d;
      fault_valid_q <= fault_valid_d;
      fault_VPN_q   <= fault_VPN_d;
      plru4m_q      <= plru4m_d;
    end
  end

  assign fill_valid  = fill_valid_q;
  assign fill_is_4MB = fill_is_4MB_q;
  assign fill_index  = fill_index_q;
  assign fill_way    = fill_way_q;
  assign fill_VPN    = fill_VPN_q;
  assign fill_ASID   = fill_ASID_q;
  assign fill_pte    = fill_pte_q;
  assign fault_valid = fault_valid_q;
  assign fault_VPN   = fault_VPN_q;

endmodule

// File: tb/tb_itlb_miss_ctrl.sv
// Directed self-checking bench for itlb_miss_ctrl.
module tb_itlb_miss_ctrl;
  import itlb_miss_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        miss_valid;
  logic [19:0] miss_VPN;
  logic [8:0]  miss_ASID;
  logic        miss_ready;
  logic        hit_valid;
  logic        hit_is_4MB;
  logic [1:0]  hit_index;
  logic [1:0]  hit_way;
  logic        l2_req_valid;
  logic        l2_req_ready;
  logic [1:0]  l2_req_tag;
  logic [19:0] l2_req_VPN;
  logic [8:0]  l2_req_ASID;
  logic        l2_resp_valid;
  logic [1:0]  l2_resp_tag;
  pte_t        l2_resp_pte;
  logic        l2_resp_is_4MB;
  logic        l2_resp_fault;
  logic        flush_valid;
  logic        fill_valid;
  logic        fill_is_4MB;
  logic [1:0]  fill_index;
  logic [1:0]  fill_way;
  logic [19:0] fill_VPN;
  logic [8:0]  fill_ASID;
  pte_t        fill_pte;
  logic        fault_valid;
  logic [19:0] fault_VPN;

  int total = 0;
  int bad   = 0;
  logic [3:0] outst;

  itlb_miss_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .miss_valid(miss_valid), .miss_VPN(miss_VPN), .miss_ASID(miss_ASID), .miss_ready(miss_ready),
    .hit_valid(hit_valid), .hit_is_4MB(hit_is_4MB), .hit_index(hit_index), .hit_way(hit_way),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_tag(l2_req_tag),
    .l2_req_VPN(l2_req_VPN), .l2_req_ASID(l2_req_ASID),
    .l2_resp_valid(l2_resp_valid), .l2_resp_tag(l2_resp_tag), .l2_resp_pte(l2_resp_pte),
    .l2_resp_is_4MB(l2_resp_is_4MB), .l2_resp_fault(l2_resp_fault),
    .flush_valid(flush_valid),
    .fill_valid(fill_valid), .fill_is_4MB(fill_is_4MB), .fill_index(fill_index),
    .fill_way(fill_way), .fill_VPN(fill_VPN), .fill_ASID(fill_ASID), .fill_pte(fill_pte),
    .fault_valid(fault_valid), .fault_VPN(fault_VPN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    miss_valid = 0; miss_VPN = '0; miss_ASID = '0;
    hit_valid = 0; hit_is_4MB = 0; hit_index = '0; hit_way = '0;
    l2_req_ready = 0;
    l2_resp_valid = 0; l2_resp_tag = '0; l2_resp_pte = '0; l2_resp_is_4MB = 0; l2_resp_fault = 0;
    flush_valid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 0;
    tick();
    tick();
    nRST = 1;
    outst = '0;
    #1;
  endtask

  task automatic present_miss(input logic [19:0] vpn, input logic [8:0] asid);
    miss_valid = 1; miss_VPN = vpn; miss_ASID = asid;
    #1;
  endtask

  task automatic drop_miss();
    miss_valid = 0; miss_VPN = '0; miss_ASID = '0;
  endtask

  task automatic accept_req(input logic [1:0] tag);
    l2_req_ready = 1;
    tick();
    l2_req_ready = 0;
    outst[tag] = 1'b1;
    #1;
  endtask

  task automatic drive_resp(input logic [1:0] tag, input pte_t pte, input logic is4, input logic flt);
    assert (outst[tag]) else $error("bench issued response to tag %0d with no request outstanding", tag);
    l2_resp_valid = 1; l2_resp_tag = tag; l2_resp_pte = pte;
    l2_resp_is_4MB = is4; l2_resp_fault = flt;
    outst[tag] = 1'b0;
  endtask

  task automatic drop_resp();
    l2_resp_valid = 0; l2_resp_tag = '0; l2_resp_pte = '0; l2_resp_is_4MB = 0; l2_resp_fault = 0;
  endtask

  // Miss -> accept -> response on tag, optionally with a concurrent 4KB hit in the response cycle
  task automatic run_fill(input logic [19:0] vpn, input logic [1:0] tag, input logic is4,
                          input logic hen, input logic [1:0] hidx, input logic [1:0] hw);
    present_miss(vpn, 9'd1);
    tick();
    drop_miss();
    accept_req(tag);
    drive_resp(tag, pte_t'(32'h0000_10CF), is4, 1'b0);
    hit_valid = hen; hit_is_4MB = 0; hit_index = hidx; hit_way = hw;
    tick();
    drop_resp();
    hit_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (l2_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", l2_req_valid); end
    total++; if (l2_req_tag !== 2'd0) begin bad++; $display("FAIL reset_req_tag got=%0d exp=0", l2_req_tag); end
    total++; if (fill_valid !== 1'b0 || fill_way !== 2'd0 || fill_VPN !== 20'd0) begin bad++; $display("FAIL reset_fill got=%b/%0d/%h exp=0/0/0", fill_valid, fill_way, fill_VPN); end
    total++; if (fault_valid !== 1'b0 || fault_VPN !== 20'd0) begin bad++; $display("FAIL reset_fault got=%b/%h exp=0/0", fault_valid, fault_VPN); end
    total++; if (miss_ready !== 1'b1) begin bad++; $display("FAIL reset_miss_ready got=%b exp=1", miss_ready); end
  endtask

  task automatic test_single_miss();
    pte_t p;
    p = pte_t'(32'h0ABC_D0CF);
    do_reset();
    present_miss(20'h12345, 9'd3);
    total++; if (miss_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", miss_ready); end
    tick();
    drop_miss();
    total++; if (l2_req_valid !== 1'b1 || l2_req_tag !== 2'd0 || l2_req_VPN !== 20'h12345 || l2_req_ASID !== 9'd3)
      begin bad++; $display("FAIL single_req got=%b/%0d/%h/%0d exp=1/0/12345/3", l2_req_valid, l2_req_tag, l2_req_VPN, l2_req_ASID); end
    accept_req(2'd0);
    total++; if (l2_req_valid !== 1'b0) begin bad++; $display("FAIL single_req_drop got=%b exp=0", l2_req_valid); end
    drive_resp(2'd0, p, 1'b0, 1'b0);
    #1;
    total++; if (fill_valid !== 1'b0) begin bad++; $display("FAIL single_fill_early got=%b exp=0", fill_valid); end
    tick();
    drop_resp();
    total++; if (fill_valid !== 1'b1 || fill_is_4MB !== 1'b0 || fill_index !== 2'd1 || fill_way !== 2'd0)
      begin bad++; $display("FAIL single_fill got=%b/%b/%0d/%0d exp=1/0/1/0", fill_valid, fill_is_4MB, fill_index, fill_way); end
    total++; if (fill_VPN !== 20'h12345 || fill_ASID !== 9'd3 || fill_pte !== p)
      begin bad++; $display("FAIL single_fill_data got=%h/%0d/%h exp=12345/3/%h", fill_VPN, fill_ASID, fill_pte, p); end
    tick();
    total++; if (fill_valid !== 1'b0) begin bad++; $display("FAIL single_fill_pulse got=%b exp=0", fill_valid); end
    present_miss(20'h00777, 9'd3);
    tick();
    drop_miss();
    total++; if (l2_req_tag !== 2'd0 || l2_req_VPN !== 20'h00777) begin bad++; $display("FAIL single_tag_free got=%0d/%h exp=0/00777", l2_req_tag, l2_req_VPN); end
  endtask

  task automatic test_merge_ooo();
    logic [19:0] vpns [4];
    logic [1:0]  otags [3];
    logic [19:0] ovpn [3];
    logic [1:0]  oway [3];
    vpns = '{20'h00010, 20'h00020, 20'h00030, 20'h00040};
    otags = '{2'd0, 2'd3, 2'd1};
    ovpn = '{20'h00010, 20'h00040, 20'h00020};
    oway = '{2'd2, 2'd1, 2'd3};
    do_reset();
    present_miss(vpns[0], 9'd1);
    tick();
    present_miss(vpns[0], 9'd1);
    total++; if (miss_ready !== 1'b1) begin bad++; $display("FAIL merge_ready got=%b exp=1", miss_ready); end
    tick();
    for (int i = 1; i < 4; i++) begin
      present_miss(vpns[i], 9'd1);
      total++; if (miss_ready !== 1'b1) begin bad++; $display("FAIL alloc_ready_%0d got=%b exp=1", i, miss_ready); end
      tick();
    end
    present_miss(20'h00050, 9'd1);
    total++; if (miss_ready !== 1'b0) begin bad++; $display("FAIL sat_ready got=%b exp=0", miss_ready); end
    tick();
    drop_miss();
    for (int i = 0; i < 4; i++) begin
      total++; if (l2_req_valid !== 1'b1 || l2_req_tag !== 2'(i) || l2_req_VPN !== vpns[i])
        begin bad++; $display("FAIL sat_req_%0d got=%b/%0d/%h exp=1/%0d/%h", i, l2_req_valid, l2_req_tag, l2_req_VPN, i, vpns[i]); end
      accept_req(2'(i));
    end
    total++; if (l2_req_valid !== 1'b0) begin bad++; $display("FAIL sat_req_empty got=%b exp=0", l2_req_valid); end
    present_miss(20'h00050, 9'd1);
    drive_resp(2'd2, pte_t'(32'h0000_20CF), 1'b0, 1'b0);
    #1;
    total++; if (miss_ready !== 1'b0) begin bad++; $display("FAIL free_same_cycle got=%b exp=0", miss_ready); end
    tick();
    drop_resp();
    total++; if (miss_ready !== 1'b1) begin bad++; $display("FAIL free_next_cycle got=%b exp=1", miss_ready); end
    total++; if (fill_valid !== 1'b1 || fill_VPN !== 20'h00030 || fill_way !== 2'd0 || fill_index !== 2'd0)
      begin bad++; $display("FAIL ooo_fill_t2 got=%b/%h/%0d/%0d exp=1/00030/0/0", fill_valid, fill_VPN, fill_way, fill_index); end
    tick();
    drop_miss();
    total++; if (l2_req_valid !== 1'b1 || l2_req_tag !== 2'd2 || l2_req_VPN !== 20'h00050)
      begin bad++; $display("FAIL realloc_req got=%b/%0d/%h exp=1/2/00050", l2_req_valid, l2_req_tag, l2_req_VPN); end
    for (int k = 0; k < 3; k++) begin
      drive_resp(otags[k], pte_t'(32'h0000_30CF), 1'b0, 1'b0);
      tick();
      total++; if (fill_valid !== 1'b1 || fill_VPN !== ovpn[k] || fill_way !== oway[k])
        begin bad++; $display("FAIL ooo_fill_%0d got=%b/%h/%0d exp=1/%h/%0d", k, fill_valid, fill_VPN, fill_way, ovpn[k], oway[k]); end
    end
    drop_resp();
    tick();
    total++; if (fill_valid !== 1'b0) begin bad++; $display("FAIL ooo_fill_end got=%b exp=0", fill_valid); end
    accept_req(2'd2);
    drive_resp(2'd2, pte_t'(32'h0040_00CF), 1'b1, 1'b0);
    tick();
    drop_resp();
    total++; if (fill_valid !== 1'b1 || fill_is_4MB !== 1'b1 || fill_index !== 2'd0 || fill_way !== 2'd0)
      begin bad++; $display("FAIL mb_fill_set0 got=%b/%b/%0d/%0d exp=1/1/0/0", fill_valid, fill_is_4MB, fill_index, fill_way); end
    run_fill(20'h00400, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0);
    total++; if (fill_valid !== 1'b1 || fill_is_4MB !== 1'b1 || fill_index !== 2'd1 || fill_way !== 2'd0 || fill_VPN !== 20'h00400)
      begin bad++; $display("FAIL mb_fill_set1 got=%b/%b/%0d/%0d/%h exp=1/1/1/0/00400", fill_valid, fill_is_4MB, fill_index, fill_way, fill_VPN); end
  endtask

  task automatic test_flush();
    do_reset();
    present_miss(20'hAAAAA, 9'd5);
    tick();
    drop_miss();
    accept_req(2'd0);
    present_miss(20'hBBBBB, 9'd5);
    tick();
    drop_miss();
    total++; if (l2_req_tag !== 2'd1) begin bad++; $display("FAIL flush_pre_tag got=%0d exp=1", l2_req_tag); end
    flush_valid = 1;
    present_miss(20'hCCCCC, 9'd5);
    total++; if (miss_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", miss_ready); end
    tick();
    flush_valid = 0;
    drop_miss();
    total++; if (l2_req_valid !== 1'b0) begin bad++; $display("FAIL flush_pend_freed got=%b exp=0", l2_req_valid); end
    present_miss(20'hAAAAA, 9'd5);
    tick();
    drop_miss();
    total++; if (l2_req_valid !== 1'b1 || l2_req_tag !== 2'd1)
      begin bad++; $display("FAIL stale_no_merge got=%b/%0d exp=1/1", l2_req_valid, l2_req_tag); end
    drive_resp(2'd0, pte_t'(32'h0000_40CF), 1'b0, 1'b0);
    tick();
    drop_resp();
    total++; if (fill_valid !== 1'b0 || fault_valid !== 1'b0)
      begin bad++; $display("FAIL stale_resp_silent got=%b/%b exp=0/0", fill_valid, fault_valid); end
    present_miss(20'hDDDDD, 9'd5);
    total++; if (miss_ready !== 1'b1) begin bad++; $display("FAIL stale_realloc_ready got=%b exp=1", miss_ready); end
    tick();
    drop_miss();
    total++; if (l2_req_tag !== 2'd1 || l2_req_VPN !== 20'hAAAAA)
      begin bad++; $display("FAIL req_stable got=%0d/%h exp=1/AAAAA", l2_req_tag, l2_req_VPN); end
    accept_req(2'd1);
    total++; if (l2_req_valid !== 1'b1 || l2_req_tag !== 2'd0 || l2_req_VPN !== 20'hDDDDD)
      begin bad++; $display("FAIL realloc_tag0 got=%b/%0d/%h exp=1/0/DDDDD", l2_req_valid, l2_req_tag, l2_req_VPN); end
    // flush in the accept cycle: tag 0 goes STALE, tag 1 WAIT goes STALE
    flush_valid = 1;
    l2_req_ready = 1;
    tick();
    flush_valid = 0;
    l2_req_ready = 0;
    outst[0] = 1'b1;
    total++; if (l2_req_valid !== 1'b0) begin bad++; $display("FAIL flush_accept got=%b exp=0", l2_req_valid); end
    present_miss(20'h11111, 9'd5);
    tick();
    drop_miss();
    total++; if (l2_req_tag !== 2'd2) begin bad++; $display("FAIL flush_accept_stale got=%0d exp=2", l2_req_tag); end
    accept_req(2'd2);
    drive_resp(2'd0, pte_t'(32'h0000_50CF), 1'b0, 1'b0);
    tick();
    drive_resp(2'd1, pte_t'(32'h0000_50CF), 1'b0, 1'b0);
    total++; if (fill_valid !== 1'b0) begin bad++; $display("FAIL stale0_fill got=%b exp=0", fill_valid); end
    tick();
    drop_resp();
    total++; if (fill_valid !== 1'b0) begin bad++; $display("FAIL stale1_fill got=%b exp=0", fill_valid); end
    // response arriving in the flush cycle is dropped
    flush_valid = 1;
    drive_resp(2'd2, pte_t'(32'h0000_60CF), 1'b0, 1'b1);
    tick();
    flush_valid = 0;
    drop_resp();
    total++; if (fill_valid !== 1'b0 || fault_valid !== 1'b0)
      begin bad++; $display("FAIL flush_resp got=%b/%b exp=0/0", fill_valid, fault_valid); end
  endtask

  task automatic test_plru();
    logic [1:0] exp_way [4];
    exp_way = '{2'd0, 2'd2, 2'd1, 2'd3};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_fill(20'(k * 16 + 256), 2'd0, 1'b0, 1'b0, 2'd0, 2'd0);
      total++; if (fill_valid !== 1'b1 || fill_index !== 2'd0 || fill_way !== exp_way[k])
        begin bad++; $display("FAIL plru_fill_%0d got=%b/%0d/%0d exp=1/0/%0d", k, fill_valid, fill_index, fill_way, exp_way[k]); end
    end
    hit_valid = 1; hit_is_4MB = 0; hit_index = 2'd0; hit_way = 2'd0;
    tick();
    hit_valid = 0;
    run_fill(20'h00100, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0);
    total++; if (fill_way !== 2'd2) begin bad++; $display("FAIL plru_after_hit got=%0d exp=2", fill_way); end
    run_fill(20'h00200, 2'd0, 1'b0, 1'b1, 2'd0, 2'd2);
    total++; if (fill_way !== 2'd1) begin bad++; $display("FAIL plru_same_cycle_victim got=%0d exp=1", fill_way); end
    run_fill(20'h00300, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0);
    total++; if (fill_way !== 2'd3) begin bad++; $display("FAIL plru_hit_then_fill got=%0d exp=3", fill_way); end
    hit_valid = 1; hit_is_4MB = 0; hit_index = 2'd1; hit_way = 2'd0;
    tick();
    hit_valid = 0;
    run_fill(20'h00001, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0);
    total++; if (fill_index !== 2'd1 || fill_way !== 2'd2) begin bad++; $display("FAIL plru_set1 got=%0d/%0d exp=1/2", fill_index, fill_way); end
  endtask

  task automatic test_fault();
    do_reset();
    present_miss(20'h54321, 9'd7);
    tick();
    drop_miss();
    accept_req(2'd0);
    drive_resp(2'd0, pte_t'(32'h0000_0000), 1'b0, 1'b1);
    tick();
    drop_resp();
    total++; if (fault_valid !== 1'b1 || fault_VPN !== 20'h54321)
      begin bad++; $display("FAIL fault_pulse got=%b/%h exp=1/54321", fault_valid, fault_VPN); end
    total++; if (fill_valid !== 1'b0) begin bad++; $display("FAIL fault_no_fill got=%b exp=0", fill_valid); end
    tick();
    total++; if (fault_valid !== 1'b0) begin bad++; $display("FAIL fault_end got=%b exp=0", fault_valid); end
  endtask

  initial begin
    clear_inputs();
    nRST = 0;
    outst = '0;
    test_reset();
    test_single_miss();
    test_merge_ooo();
    test_flush();
    test_plru();
    test_fault();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/itlb_miss_ctrl.md
Name: itlb_miss_ctrl

Overview:
- Sequences ITLB refills.
- Accepts ITLB misses, allocates one of ITLB_L2_TLB_REQ_TAG_COUNT (4) L2 TLB request tags, and issues requests to the L2 TLB. Misses to the same page are merged onto one tag.
- Routes tagged responses into fill commands for the 4KB array (4 sets x 4 ways) or the 4MB array (2 sets x 2 ways). The victim way comes from per-set PLRU state owned by this block.
- Sits between the ITLB lookup stage and the L2 TLB interface.

Parameters:
- TAG_COUNT, ITLB_L2_TLB_REQ_TAG_COUNT (4), number of outstanding L2 TLB requests.
- TAG_WIDTH, ITLB_L2_TLB_REQ_TAG_WIDTH (2), request tag width.

Ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- miss_valid  in  1  ITLB lookup missed
- miss_VPN  in  20  missing VPN
- miss_ASID  in  9  ASID of the miss
- miss_ready  out  1  miss accepted, either allocated or merged
- hit_valid  in  1  ITLB hit, for PLRU update
- hit_is_4MB  in  1  hit was in the 4MB array
- hit_index  in  2  set index; 4MB uses bit 0 only
- hit_way  in  2  hit way; 4MB uses bit 0 only
- l2_req_valid  out  1  request to L2 TLB
- l2_req_ready  in  1  L2 TLB accepts the request
- l2_req_tag  out  2  request tag
- l2_req_VPN  out  20  request VPN
- l2_req_ASID  out  9  request ASID
- l2_resp_valid  in  1  L2 TLB response
- l2_resp_tag  in  2  response tag
- l2_resp_pte  in  pte_t (32)  leaf PTE
- l2_resp_is_4MB  in  1  leaf at level 1
- l2_resp_fault  in  1  page fault / access fault
- flush_valid  in  1  sfence.vma; no ASID/VA filtering
- fill_valid  out  1  write ITLB entry
- fill_is_4MB  out  1  target array
- fill_index  out  2  set index
- fill_way  out  2  victim way
- fill_VPN  out  20  VPN for the tag write
- fill_ASID  out  9  ASID for the tag write
- fill_pte  out  pte_t (32)  PTE for the entry write
- fault_valid  out  1  fault pulse to fetch
- fault_VPN  out  20  faulting VPN

Behaviour:
- Reset (nRST=0 at a CLK edge):
  - all tag entries FREE, all PLRU bits 0
  - all valid outputs 0; all data outputs 0
- Tag entry state per tag:
  - FREE -> PEND on allocation
  - PEND -> WAIT on l2_req accept
  - WAIT -> FREE on response
  - WAIT -> STALE on flush
  - STALE -> FREE on response
  - Each entry holds VPN and ASID.
- Miss accept, combinational miss_ready:
  - Merge: any PEND/WAIT entry with equal VPN and ASID gives miss_ready=1 with no allocation.
  - Otherwise miss_ready=1 iff some entry is FREE. The lowest-index FREE entry becomes PEND at the next edge.
  - STALE entries never merge.
  - miss_ready=0 whenever flush_valid=1.
- Request issue:
  - l2_req_valid=1 iff any PEND entry exists; the lowest-index PEND entry is presented.
  - Once valid, tag, VPN and ASID stay stable until l2_req_ready. No retraction except by flush.
- Response:
  - l2_resp_valid with the tag in WAIT frees the tag at the next edge.
  - A tag in STALE is freed silently, with no fill and no fault.
  - A response to a FREE or PEND tag is illegal. The design ignores it; the bench asserts it never happens.
- Fill (registered, 1-cycle latency after a WAIT response with fault=0):
  - fill_is_4MB = l2_resp_is_4MB.
  - fill_index: 4KB uses VPN[1:0]; 4MB uses {1'b0, VPN[10]}.
  - fill_way is taken from PLRU before the update. 4KB uses a 3-bit tree PLRU per set; 4MB uses a 1-bit PLRU per set.
  - fill_valid pulses one cycle.
- Fault: fault=1 gives a registered fault_valid/fault_VPN pulse one cycle after the response, with no fill.
- PLRU update:
  - A hit or a fill marks that way MRU.
  - If a hit and a fill land in the same cycle and the same set, the hit update is applied first and the fill update last.
  - Victim choice reads the pre-update state.
- Flush, same cycle:
  - PEND entries -> FREE. Exception: the presented entry accepted this cycle (l2_req_valid & l2_req_ready) -> STALE.
  - WAIT -> STALE.
  - A response arriving in the flush cycle is treated as STALE: no fill or fault is produced, and the tag is freed.
  - PLRU is unaffected.
- Simultaneous events in one cycle are legal together:
  - allocate and free of different tags
  - response and request accept on the same tag (WAIT->FREE is not possible for a PEND tag; the accept is applied)
  - A tag freed this cycle is allocatable only from the next cycle.
- Reset mid-operation clears all entries. Late L2 responses after reset are illegal, and the system guarantees this.

Decomposition:
- Add to system_types_pkg:
  - ITLB_L2_TLB_REQ_TAG_COUNT and ITLB_L2_TLB_REQ_TAG_WIDTH (already present)
  - itlb_miss_tag_state_t enum {FREE, PEND, WAIT, STALE}
  - ITLB_4KBPAGE/4MBPAGE sizing constants (already present)
- One natural sub-module, plru_tree4: 3-bit tree PLRU with victim output and touch input. It is instantiated per 4KB set; the 1-bit 4MB PLRU stays inline.

Test Plan:
- Single miss: miss VPN=0x12345, ASID=3 -> l2_req tag 0. Response tag 0, 4KB PTE -> fill_valid one cycle later with index 1, way 0; the tag is then FREE.
- Merge and saturation: misses to 0x00010, 0x00010, 0x00020, 0x00030, 0x00040 with l2_req_ready=0 -> tags 0-3 are allocated, the second miss merges, and a fifth distinct miss sees miss_ready=0 until any response frees a tag.
- Out-of-order responses on tags 2, 0, 3, 1 -> fills in response order with the correct VPN each. 4MB response for VPN 0x00400 -> fill_is_4MB=1, index 1.
- Flush with tag 0 WAIT and tag 1 PEND -> tag 1 FREE immediately. The tag 0 response produces no fill, and tag 0 is reallocatable the next cycle.
- PLRU: four fills to 4KB set 0 -> ways 0, 2, 1, 3. A hit on way 0 followed by a fill to set 0 -> victim way 2.
- Fault response tag 0 -> fault_valid with fault_VPN equal to the request VPN, and fill_valid stays 0.
